xor_serial_arbiter: RTL and testbench

XOR_SERIAL_ARBITER -- requirements
Module: xor_serial_arbiter

---
 rtl/xor_arb_pkg.sv | 22 ++
 rtl/xor_bit_cell.sv | 19 +
 rtl/xor_serial_arbiter.sv | 109 ++++++++++
 tb/tb_xor_serial_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_arb_pkg.sv
// Shared definitions for the serial XOR arbiter: default width, FSM state
// encodings, last-served pointer reset value and the round-robin pick.
package xor_arb_pkg;

  localparam int unsigned XOR_ARB_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } arb_state_t;

  // Pointer starts at 1 so requester 0 wins the first tie.
  localparam logic LAST_RST = 1'b1;

  // Returns the requester to grant (0 or 1); only meaningful when a request is pending.
  function automatic logic arb_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

endpackage

// File: rtl/xor_bit_cell.sv
// One-bit XOR made only from two-input NOR primitives.
module xor_bit_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  logic w_n1;
  logic w_n2;
  logic w_n3;
  logic w_xnor;

  nor g_n1   (w_n1,   i_a,    i_b);
  nor g_n2   (w_n2,   i_a,    w_n1);
  nor g_n3   (w_n3,   i_b,    w_n1);
  nor g_xnor (w_xnor, w_n2,   w_n3);
  nor g_inv  (o_y,    w_xnor, w_xnor);

endmodule

// File: rtl/xor_serial_arbiter.sv
// Two-requester round-robin arbiter feeding a bit-serial XOR datapath that
// computes a ^ b one bit per cycle through a single shared xor_bit_cell.
module xor_serial_arbiter
  import xor_arb_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_ARB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             owner
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  arb_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_sel;

  logic             w_bit;
  logic             w_take;
  logic             w_pick;
  logic [WIDTH-1:0] w_acc_next;

  xor_bit_cell u_cell (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .o_y (w_bit)
  );

  always_comb begin
    w_take     = req0 | req1;
    w_pick     = arb_pick(req0, req1, r_last);
    w_acc_next = {w_bit, r_acc[WIDTH-1:1]};
  end

  // Shifting happens in r_acc so result/owner stay stable until the next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_last  <= LAST_RST;
      r_sel   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      owner   <= 1'b0;
      result  <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_a     <= w_pick ? a1 : a0;
            r_b     <= w_pick ? b1 : b0;
            r_sel   <= w_pick;
            r_last  <= w_pick;
            gnt0    <= ~w_pick;
            gnt1    <= w_pick;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            result  <= w_acc_next;
            owner   <= r_sel;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed bench for xor_serial_arbiter (WIDTH=8) and its NOR-based XOR cell.
module tb_xor_serial_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0;
  logic [7:0] a0 = '0;
  logic [7:0] b0 = '0;
  logic       req1 = 1'b0;
  logic [7:0] a1 = '0;
  logic [7:0] b1 = '0;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic [7:0] result;
  logic       done;
  logic       owner;

  logic c_a = 1'b0;
  logic c_b = 1'b0;
  logic c_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_serial_arbiter #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .busy   (busy),
    .result (result),
    .done   (done),
    .owner  (owner)
  );

  xor_bit_cell u_cell (
    .i_a (c_a),
    .i_b (c_b),
    .o_y (c_y)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    total++;
    if ({gnt0, gnt1, busy, done, owner, result} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got g0=%b g1=%b busy=%b done=%b own=%b res=%h, want all 0",
               gnt0, gnt1, busy, done, owner, result);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_cell;
    logic [3:0] tbl;
    tbl = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      c_a = i[1];
      c_b = i[0];
      #1;
      total++;
      if (c_y !== tbl[i]) begin
        bad++;
        $display("FAIL cell_%0d%0d: got %b want %b", c_a, c_b, c_y, tbl[i]);
      end
    end
  endtask

  task automatic test_single;
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_grant: got g0=%b g1=%b busy=%b done=%b want 1 0 1 0", gnt0, gnt1, busy, done);
    end
    req0 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== (i <= 8) || done !== (i == 8)) begin
        bad++;
        $display("FAIL single_k+%0d: got g0=%b g1=%b busy=%b done=%b want 0 0 %b %b",
                 i, gnt0, gnt1, busy, done, (i <= 8), (i == 8));
      end
      if (i >= 8) begin
        total++;
        if (result !== 8'hAA || owner !== 1'b0) begin
          bad++;
          $display("FAIL single_result_k+%0d: got %h/%b want aa/0", i, result, owner);
        end
      end
    end
  endtask

  task automatic test_drop;
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
    #3;
    req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || result !== 8'hAA) begin
        bad++;
        $display("FAIL drop_%0d: got g0=%b g1=%b busy=%b res=%h want 0 0 0 aa", i, gnt0, gnt1, busy, result);
      end
    end
  endtask

  task automatic test_tie;
    do_reset();
    req0 = 1'b1; a0 = 8'h30; b0 = 8'h0C;
    req1 = 1'b1; a1 = 8'hC0; b1 = 8'h03;
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL tie_first: got g0=%b g1=%b want 1 0", gnt0, gnt1);
    end
    req0 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 8) begin
        total++;
        if (done !== 1'b1 || result !== 8'h3C || owner !== 1'b0) begin
          bad++;
          $display("FAIL tie_done0: got done=%b res=%h own=%b want 1 3c 0", done, result, owner);
        end
      end
      total++;
      if (gnt1 !== (i == 10) || gnt0 !== 1'b0) begin
        bad++;
        $display("FAIL tie_gnt_k+%0d: got g0=%b g1=%b want 0 %b", i, gnt0, gnt1, (i == 10));
      end
    end
    req1 = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    total++;
    if (done !== 1'b1 || result !== 8'hC3 || owner !== 1'b1) begin
      bad++;
      $display("FAIL tie_done1: got done=%b res=%h own=%b want 1 c3 1", done, result, owner);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'h00;
    tick();
    req0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_pre_k+%0d: got done=%b busy=%b want 0 1", i, done, busy);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1, busy, done, owner, result} !== 13'd0) begin
      bad++;
      $display("FAIL rstmid_async: got g0=%b g1=%b busy=%b done=%b own=%b res=%h want all 0",
               gnt0, gnt1, busy, done, owner, result);
    end
    tick();
    tick();
    rst = 1'b0;
    req1 = 1'b1; a1 = 8'h12; b1 = 8'h34;
    tick();
    total++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_regrant: got g0=%b g1=%b done=%b want 0 1 0", gnt0, gnt1, done);
    end
    req1 = 1'b0;
    for (int i = 1; i <= 8; i++) tick();
    total++;
    if (done !== 1'b1 || result !== 8'h26 || owner !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_result: got done=%b res=%h own=%b want 1 26 1", done, result, owner);
    end
    tick();
  endtask

  task automatic test_operand_change;
    req1 = 1'b1; a1 = 8'h5A; b1 = 8'hFF;
    tick();
    total++;
    if (gnt1 !== 1'b1) begin
      bad++;
      $display("FAIL opchg_grant: got g1=%b want 1", gnt1);
    end
    tick();
    tick();
    a1 = 8'h00; b1 = 8'h00; req1 = 1'b0;
    for (int i = 3; i <= 8; i++) tick();
    total++;
    if (done !== 1'b1 || result !== 8'hA5 || owner !== 1'b1) begin
      bad++;
      $display("FAIL opchg_result: got done=%b res=%h own=%b want 1 a5 1", done, result, owner);
    end
    for (int i = 9; i <= 11; i++) begin
      tick();
      total++;
      if (gnt1 !== 1'b0 || busy !== (i == 8)) begin
        bad++;
        $display("FAIL opchg_idle_k+%0d: got g1=%b busy=%b want 0 0", i, gnt1, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h00;
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h00;
    for (int t = 0; t < 40; t++) begin
      tick();
      total++;
      if (gnt0 !== (t % 20 == 0) || gnt1 !== (t % 20 == 10) ||
          done !== (t % 10 == 8) || busy !== (t % 10 <= 8)) begin
        bad++;
        $display("FAIL b2b_t%0d: got g0=%b g1=%b done=%b busy=%b want %b %b %b %b", t,
                 gnt0, gnt1, done, busy, (t % 20 == 0), (t % 20 == 10), (t % 10 == 8), (t % 10 <= 8));
      end
      if (t % 10 == 8) begin
        total++;
        if (result !== ((t % 20 == 8) ? 8'h01 : 8'h80) || owner !== (t % 20 == 18)) begin
          bad++;
          $display("FAIL b2b_res_t%0d: got %h/%b want %h/%b", t, result, owner,
                   ((t % 20 == 8) ? 8'h01 : 8'h80), (t % 20 == 18));
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    test_reset();
    test_cell();
    test_single();
    test_drop();
    test_tie();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
